// File: rtl/vga_timing_pkg.sv
// Shared VGA timing constants and the sync/blank triple carried through the delay line.
// Defaults describe 640x480 at 60 Hz with a 25 MHz pixel rate from a 50 MHz Clk.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  // Sync pulse windows are half-open: [START, END)
  localparam int HS_START  = H_VISIBLE + H_FP;
  localparam int HS_END    = HS_START + H_SYNC;
  localparam int VS_START  = V_VISIBLE + V_FP;
  localparam int VS_END    = VS_START + V_SYNC;

  localparam int PIX_DIV    = 2;
  localparam int PIPE_DELAY = 2;

  typedef struct packed {
    logic hs;
    logic vs;
    logic blank_n;
  } sync_t;

  localparam sync_t SYNC_IDLE = '{hs: 1'b1, vs: 1'b1, blank_n: 1'b0};

endpackage

// File: rtl/vga_timing_gen_if.sv
// Pixel-position and VGA control bundle between the timing master and color_mapper.
// pix_en qualifies DrawX/DrawY: the mapper takes a new pixel on each Clk edge where pix_en is high; there is no back-pressure.
interface vga_timing_gen_if;

  logic [9:0] DrawX;
  logic [9:0] DrawY;
  logic       pix_en;
  logic       frame_start;
  logic       VGA_CLK;
  logic       VGA_HS;
  logic       VGA_VS;
  logic       VGA_BLANK_N;
  logic       VGA_SYNC_N;

  modport master (
    output DrawX, DrawY, pix_en, frame_start,
    output VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
  );

  modport slave (
    input DrawX, DrawY, pix_en, frame_start,
    input VGA_CLK, VGA_HS, VGA_VS, VGA_BLANK_N, VGA_SYNC_N
  );

endinterface

// File: rtl/vga_sync_delay.sv
// Fixed-depth shift register that holds HS/VS/BLANK_N back by the mapper's RGB latency.
// Reset fills every stage with the idle triple so no partial sync pulse leaks out.
module vga_sync_delay
  import vga_timing_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic  Clk,
  input  logic  Reset_n,
  input  sync_t i_sync,
  output sync_t o_sync
);

  sync_t r_pipe [DEPTH];

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < DEPTH; i++) r_pipe[i] <= SYNC_IDLE;
    end else begin
      r_pipe[0] <= i_sync;
      for (int i = 1; i < DEPTH; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  assign o_sync = r_pipe[DEPTH-1];

endmodule

// File: rtl/vga_timing_gen.sv
// VGA pixel-timing master: pixel-rate divider, scan counters, sync/blank decode and
// a delay line aligning sync/blank with the mapper's registered RGB path.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int H_FP       = vga_timing_pkg::H_FP,
  parameter int H_SYNC     = vga_timing_pkg::H_SYNC,
  parameter int H_BP       = vga_timing_pkg::H_BP,
  parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE,
  parameter int V_FP       = vga_timing_pkg::V_FP,
  parameter int V_SYNC     = vga_timing_pkg::V_SYNC,
  parameter int V_BP       = vga_timing_pkg::V_BP,
  parameter int PIX_DIV    = vga_timing_pkg::PIX_DIV,
  parameter int PIPE_DELAY = vga_timing_pkg::PIPE_DELAY
) (
  input  logic              Clk,
  input  logic              Reset_n,
  vga_timing_gen_if.master  vga
);

  localparam int DW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

  localparam logic [9:0] H_LAST   = 10'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] V_LAST   = 10'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] L_HS_BEG = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] L_HS_END = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] L_VS_BEG = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] L_VS_END = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic [9:0] L_H_VIS  = 10'(H_VISIBLE);
  localparam logic [9:0] L_V_VIS  = 10'(V_VISIBLE);

  logic [DW-1:0] r_div;
  logic [DW-1:0] w_div_next;
  logic          w_pix_en;
  logic          r_vga_clk;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic          r_frame_start;
  sync_t         w_raw;
  sync_t         w_dly;

  assign w_pix_en   = (r_div == DW'(PIX_DIV - 1));
  assign w_div_next = w_pix_en ? '0 : r_div + 1'b1;

  // VGA_CLK is registered from the next divider value so it tracks div >= PIX_DIV/2 in the same cycle
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_div     <= '0;
      r_vga_clk <= 1'b0;
    end else begin
      r_div     <= w_div_next;
      r_vga_clk <= (w_div_next >= DW'(PIX_DIV / 2));
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_x           <= '0;
      r_y           <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_frame_start <= w_pix_en && (r_x == H_LAST) && (r_y == V_LAST);
      if (w_pix_en) begin
        if (r_x == H_LAST) begin
          r_x <= '0;
          r_y <= (r_y == V_LAST) ? 10'd0 : r_y + 10'd1;
        end else begin
          r_x <= r_x + 10'd1;
        end
      end
    end
  end

  always_comb begin
    w_raw         = SYNC_IDLE;
    w_raw.hs      = !((r_x >= L_HS_BEG) && (r_x < L_HS_END));
    w_raw.vs      = !((r_y >= L_VS_BEG) && (r_y < L_VS_END));
    w_raw.blank_n = (r_x < L_H_VIS) && (r_y < L_V_VIS);
  end

  vga_sync_delay #(
    .DEPTH (PIPE_DELAY)
  ) u_sync_delay (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .i_sync  (w_raw),
    .o_sync  (w_dly)
  );

  assign vga.DrawX       = r_x;
  assign vga.DrawY       = r_y;
  assign vga.pix_en      = w_pix_en;
  assign vga.frame_start = r_frame_start;
  assign vga.VGA_CLK     = r_vga_clk;
  assign vga.VGA_HS      = w_dly.hs;
  assign vga.VGA_VS      = w_dly.vs;
  assign vga.VGA_BLANK_N = w_dly.blank_n;
  assign vga.VGA_SYNC_N  = 1'b0;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default 640x480, and two shrunken geometries
// with different PIX_DIV/PIPE_DELAY) share a clock and randomly timed resets.
module tb_vga_timing_gen;

  localparam int W = 27;

  // shrunken geometry A: PIX_DIV=2, PIPE_DELAY=2
  localparam int S_HV = 16, S_HF = 4, S_HS = 6, S_HB = 4;
  localparam int S_VV = 10, S_VF = 2, S_VS = 2, S_VB = 3;
  // shrunken geometry B: PIX_DIV=4, PIPE_DELAY=3
  localparam int P_HV = 12, P_HF = 3, P_HS = 5, P_HB = 4;
  localparam int P_VV = 8,  P_VF = 2, P_VS = 3, P_VB = 2;

  logic clk;
  logic rst_n;

  vga_timing_gen_if if_d ();
  vga_timing_gen_if if_s ();
  vga_timing_gen_if if_p ();

  vga_timing_gen dut_d (
    .Clk     (clk),
    .Reset_n (rst_n),
    .vga     (if_d)
  );

  vga_timing_gen #(
    .H_VISIBLE (S_HV), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
    .V_VISIBLE (S_VV), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
    .PIX_DIV (2), .PIPE_DELAY (2)
  ) dut_s (
    .Clk     (clk),
    .Reset_n (rst_n),
    .vga     (if_s)
  );

  vga_timing_gen #(
    .H_VISIBLE (P_HV), .H_FP (P_HF), .H_SYNC (P_HS), .H_BP (P_HB),
    .V_VISIBLE (P_VV), .V_FP (P_VF), .V_SYNC (P_VS), .V_BP (P_VB),
    .PIX_DIV (4), .PIPE_DELAY (3)
  ) dut_p (
    .Clk     (clk),
    .Reset_n (rst_n),
    .vga     (if_p)
  );

  logic [W-1:0] act_d, act_s, act_p;
  assign act_d = {if_d.DrawX, if_d.DrawY, if_d.pix_en, if_d.frame_start, if_d.VGA_CLK,
                  if_d.VGA_HS, if_d.VGA_VS, if_d.VGA_BLANK_N, if_d.VGA_SYNC_N};
  assign act_s = {if_s.DrawX, if_s.DrawY, if_s.pix_en, if_s.frame_start, if_s.VGA_CLK,
                  if_s.VGA_HS, if_s.VGA_VS, if_s.VGA_BLANK_N, if_s.VGA_SYNC_N};
  assign act_p = {if_p.DrawX, if_p.DrawY, if_p.pix_en, if_p.frame_start, if_p.VGA_CLK,
                  if_p.VGA_HS, if_p.VGA_VS, if_p.VGA_BLANK_N, if_p.VGA_SYNC_N};

  logic [3*W-1:0] exp_q[$];
  int tests  = 0;
  int errors = 0;
  int n      = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // State after n Clk edges since reset release, derived purely from elapsed time:
  // pixel index = n / PIX_DIV, raster position from that, sync outputs from time n - PIPE_DELAY.
  function automatic logic [W-1:0] model(input int t, input int hv, input int hf, input int hsw,
                                         input int hb, input int vv, input int vf, input int vsw,
                                         input int vb, input int p, input int d);
    int ht, vt, q, x, y, m, xd, yd;
    logic hs, vs, bl, pe, fs, vc;
    ht = hv + hf + hsw + hb;
    vt = vv + vf + vsw + vb;
    q  = t / p;
    x  = q % ht;
    y  = (q / ht) % vt;
    pe = ((t % p) == p - 1);
    vc = ((t % p) >= p / 2);
    fs = (t > 0) && ((t % (ht * vt * p)) == 0);
    hs = 1'b1;
    vs = 1'b1;
    bl = 1'b0;
    if (t >= d) begin
      m  = (t - d) / p;
      xd = m % ht;
      yd = (m / ht) % vt;
      hs = !((xd >= hv + hf) && (xd < hv + hf + hsw));
      vs = !((yd >= vv + vf) && (yd < vv + vf + vsw));
      bl = (xd < hv) && (yd < vv);
    end
    return {x[9:0], y[9:0], pe, fs, vc, hs, vs, bl, 1'b0};
  endfunction

  function automatic logic [3*W-1:0] model_all(input int t);
    return {model(t, 640, 16, 96, 48, 480, 10, 2, 33, 2, 2),
            model(t, S_HV, S_HF, S_HS, S_HB, S_VV, S_VF, S_VS, S_VB, 2, 2),
            model(t, P_HV, P_HF, P_HS, P_HB, P_VV, P_VF, P_VS, P_VB, 4, 3)};
  endfunction

  // ---------------- scoreboard compare ----------------
  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t n=%0d got X=%0d Y=%0d pe/fs/clk/hs/vs/bn/sn=%b required X=%0d Y=%0d pe/fs/clk/hs/vs/bn/sn=%b",
               name, $time, n, act[26:17], act[16:7], act[6:0], exp[26:17], exp[16:7], exp[6:0]);
    end
  endtask

  // ---------------- driver ----------------
  // One Clk of stimulus: drive reset at the falling edge and queue the state expected after the next rising edge.
  task automatic step(input logic rst);
    logic prev;
    logic [3*W-1:0] e;
    @(negedge clk);
    prev  = rst_n;
    rst_n = rst ? 1'b0 : 1'b1;
    if (rst) n = 0;
    else     n++;
    exp_q.push_back(model_all(n));
    if (rst && prev) begin
      // asynchronous reset must take effect before any Clk edge
      #1;
      e = model_all(0);
      check("async_rst_dflt", act_d, e[3*W-1:2*W]);
      check("async_rst_s",    act_s, e[2*W-1:W]);
      check("async_rst_p",    act_p, e[W-1:0]);
    end
  endtask

  // ---------------- monitor ----------------
  initial begin
    logic [3*W-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("dflt", act_d, e[3*W-1:2*W]);
        check("geo_s", act_s, e[2*W-1:W]);
        check("geo_p", act_p, e[W-1:0]);
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int run_len;
    int rst_len;
    rst_n = 1'b0;
    repeat (3) step(1'b1);
    for (int seg = 0; seg < 4; seg++) begin
      run_len = $urandom_range(4500, 3000);
      rst_len = $urandom_range(3, 1);
      repeat (run_len) step(1'b0);
      repeat (rst_len) step(1'b1);
    end
    repeat (2000) step(1'b0);
    @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d queued entries required 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
